joystick_autorepeat_ctrl: RTL and testbench
===========================================

// Module: joystick_autorepeat_ctrl
// PURPOSE
//  Turns N debounced button levels (4 joystick directions + fire) into move/fire pulses for the sprite movement logic.
//  - Press gives one immediate pulse.
//  - Holding the button gives a second pulse after HOLD_TICKS, then one pulse every REPEAT_TICKS.
//  - All channels share one free-running tick generator; a per-channel FSM schedules each channel against it.
//  - Sits between the debounced-button outputs and the sprite position update.
// PARAMETERS
//  N_BTN         5          number of button channels
//  TICK_CYCLES   1_000_000  clk cycles per tick (10 ms @ 100 MHz); must be >= 2
//  HOLD_TICKS    40         ticks from the press pulse to the first repeat pulse; must be >= 1
//  REPEAT_TICKS  10         ticks between repeat pulses; must be >= 2
//  ACCEL_AFTER   4          repeat pulses before the period is halved (used only with the macro)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  enable     in   1      1 = run; 0 = tick counter cleared, all channels forced to IDLE
//  btn_level  in   N_BTN  debounced button levels, synchronous to clk, 1 = pressed
//  pulse      out  N_BTN  one-cycle action pulse per channel, registered
//  held       out  N_BTN  1 while the channel is in DELAY or REPEAT, registered
//  tick       out  1      shared tick strobe, high for one cycle
// BEHAVIOUR
//  Reset: tick counter = 0; all FSMs = IDLE; channel counters = 0; pulse = 0, held = 0, tick = 0.
//  Tick generator:
//  - Counts 0..TICK_CYCLES-1 while enable = 1, then wraps to 0.
//  - tick = 1 in the cycle the count equals TICK_CYCLES-1.
//  - enable = 0 clears the count to 0 synchronously.
//  Per-channel FSM, states IDLE / DELAY / REPEAT; cnt is the per-channel tick count:
//  - IDLE, btn = 1: next cycle pulse = 1; go to DELAY with cnt = 0.
//  - DELAY, btn = 0: go to IDLE with no pulse. Release has priority over a same-cycle tick.
//  - DELAY, tick with cnt == HOLD_TICKS-1: pulse next cycle; go to REPEAT with cnt = 0.
//  - DELAY, any other tick: cnt++.
//  - REPEAT, btn = 0: go to IDLE. Release has priority over a same-cycle tick.
//  - REPEAT, tick with cnt == period-1: pulse next cycle; cnt = 0.
//  - REPEAT, any other tick: cnt++.
//  Timing consequences:
//  - Press-pulse latency is exactly 1 clk.
//  - First repeat arrives HOLD_TICKS tick strobes after the press. Phase is not realigned, so wall time = (HOLD_TICKS-1)..HOLD_TICKS tick periods.
//  Channels are independent; any number may pulse in the same cycle (no arbitration, no opposing-direction masking).
//  cnt width = $clog2(max(HOLD_TICKS, REPEAT_TICKS)+1); cnt never exceeds its terminal value and never wraps.
//  Mid-operation events:
//  - Button released and re-pressed in consecutive cycles: IDLE for one cycle, then a fresh press pulse.
//  - enable 1->0: next cycle all pulse = 0 and held = 0; pulses already in flight are dropped.
//  - reset_n asserted mid-operation: immediately returns to the reset values.
// CONFIGURATION
//  Macro AUTOREPEAT_ACCEL_EN.
//  - Defined: each channel has a repeat counter, saturating at ACCEL_AFTER, cleared on entry to REPEAT.
//    Once it saturates, period = max(REPEAT_TICKS/2, 1); otherwise period = REPEAT_TICKS.
//  - Undefined: period = REPEAT_TICKS always; ACCEL_AFTER is ignored and no repeat counter is built.
// STRUCTURE
//  Package autorepeat_pkg holds:
//  - typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} ar_state_t;
//  - function cnt_width(hold, rep) returning the cnt width.
//  Sub-module autorepeat_tick_gen (parameter TICK_CYCLES; ports clk, reset_n, enable, tick), one instance.
//  Per-channel FSMs are a generate loop inside this module.
// TESTING  (params: TICK_CYCLES=4, HOLD_TICKS=3, REPEAT_TICKS=2, ACCEL_AFTER=2, N_BTN=5)
//  1. Reset, enable = 1, no press -> tick every 4 clk; pulse = 0 and held = 0 throughout.
//  2. btn[0] = 1 and held -> pulse[0] one cycle after the press; next pulse on the 3rd tick after the press;
//     then one pulse every 2nd tick; held[0] = 1 throughout.
//  3. btn[1] pressed, released before the 3rd tick -> exactly one pulse; held[1] falls 1 clk after release.
//  4. btn[2] and btn[4] pressed in the same cycle -> both pulse in the same cycle; later pulses are identical.
//     btn[2] released in the cycle of a terminal tick -> no pulse on channel 2.
//  5. enable dropped mid-REPEAT for 3 clk, then raised with the button still pressed -> pulse and held cleared;
//     tick count restarts at 0; a new press pulse 1 clk after enable rises.
//  6. With AUTOREPEAT_ACCEL_EN -> after 2 repeat pulses, the repeat period is 1 tick.
//     Without it -> the period stays at 2 ticks.
//  Throughout: reset_n pulsed mid-DELAY returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/autorepeat_pkg.sv
// Shared types and helpers for the joystick auto-repeat controller.
// Optional repeat acceleration is selected with the AUTOREPEAT_ACCEL_EN macro.
package autorepeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } ar_state_t;

  // Width of a per-channel tick counter that must reach max(hold, rep) without wrapping.
  function automatic int cnt_width(input int hold, input int rep);
    int m;
    m = (hold > rep) ? hold : rep;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/autorepeat_tick_gen.sv
// Free-running tick strobe shared by all auto-repeat channels.
// Count runs 0..TICK_CYCLES-1 while enabled; tick is high while the count sits at TICK_CYCLES-1.
module autorepeat_tick_gen #(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(TICK_CYCLES);
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] count_q, count_d;
  logic         tick_q, tick_d;

  always_comb begin
    count_d = '0;
    if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
    // Registered decode of the next count keeps tick aligned with count == LAST.
    tick_d = (count_d == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/joystick_autorepeat_ctrl.sv
// Per-button press/hold/repeat pulse generator driven by one shared tick.
// Define AUTOREPEAT_ACCEL_EN to halve the repeat period after ACCEL_AFTER repeats.
module joystick_autorepeat_ctrl
  import autorepeat_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int TICK_CYCLES  = 1_000_000,
  parameter int HOLD_TICKS   = 40,
  parameter int REPEAT_TICKS = 10,
  parameter int ACCEL_AFTER  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] held,
  output logic             tick
);

  localparam int CNT_W = cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`ifdef AUTOREPEAT_ACCEL_EN
  localparam int FAST_TICKS = (REPEAT_TICKS / 2 > 1) ? REPEAT_TICKS / 2 : 1;
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_TICKS - 1);
  localparam int ACC_W = $clog2(ACCEL_AFTER + 2);
  localparam logic [ACC_W-1:0] ACC_SAT = ACC_W'(ACCEL_AFTER);
`endif

  autorepeat_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    ar_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_last;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
`ifdef AUTOREPEAT_ACCEL_EN
    logic [ACC_W-1:0] rep_q, rep_d;
    assign period_last = (rep_q == ACC_SAT) ? FAST_LAST : REP_LAST;
`else
    assign period_last = REP_LAST;
`endif

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
`ifdef AUTOREPEAT_ACCEL_EN
      rep_d   = rep_q;
`endif
      if (!enable) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (btn_level[i]) begin
              pulse_d = 1'b1;
              state_d = ST_DELAY;
              cnt_d   = '0;
            end
          end
          ST_DELAY: begin
            // Release wins over a tick arriving in the same cycle.
            if (!btn_level[i]) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (tick) begin
              if (cnt_q == HOLD_LAST) begin
                pulse_d = 1'b1;
                state_d = ST_REPEAT;
                cnt_d   = '0;
`ifdef AUTOREPEAT_ACCEL_EN
                rep_d   = '0;
`endif
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (!btn_level[i]) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (tick) begin
              if (cnt_q == period_last) begin
                pulse_d = 1'b1;
                cnt_d   = '0;
`ifdef AUTOREPEAT_ACCEL_EN
                if (rep_q != ACC_SAT) rep_d = rep_q + 1'b1;
`endif
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        held_q  <= 1'b0;
`ifdef AUTOREPEAT_ACCEL_EN
        rep_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        held_q  <= held_d;
`ifdef AUTOREPEAT_ACCEL_EN
        rep_q   <= rep_d;
`endif
      end
    end

    assign pulse[i] = pulse_q;
    assign held[i]  = held_q;
  end

endmodule

// File: tb/tb_joystick_autorepeat_ctrl.sv
// Randomized and directed stimulus for joystick_autorepeat_ctrl against a scheduling model.
// Build with +define+AUTOREPEAT_ACCEL_EN to exercise the accelerated repeat path.
module tb_joystick_autorepeat_ctrl;

  localparam int N     = 5;
  localparam int TICK  = 4;
  localparam int HOLD  = 3;
  localparam int REP   = 2;
  localparam int ACCEL = 2;
  localparam int W     = 2 * N + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] btn_level = '0;
  logic [N-1:0] pulse;
  logic [N-1:0] held;
  logic         tick;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: wall-clock tick count plus per-press tick bookkeeping.
  int m_c = 0;
  bit m_active[N] = '{default: 1'b0};
  int m_ticks[N]  = '{default: 0};
  int m_target[N] = '{default: 0};
  int m_reps[N]   = '{default: 0};

  joystick_autorepeat_ctrl #(
    .N_BTN       (N),
    .TICK_CYCLES (TICK),
    .HOLD_TICKS  (HOLD),
    .REPEAT_TICKS(REP),
    .ACCEL_AFTER (ACCEL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .btn_level(btn_level),
    .pulse    (pulse),
    .held     (held),
    .tick     (tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic int period_for(input int reps);
`ifdef AUTOREPEAT_ACCEL_EN
    if (reps >= ACCEL) return (REP / 2 > 1) ? REP / 2 : 1;
`endif
    return REP;
  endfunction

  always @(negedge reset_n) begin
    m_c = 0;
    for (int i = 0; i < N; i++) m_active[i] = 1'b0;
  end

  always @(posedge clk) begin : model
    logic         tk;
    logic [N-1:0] p;
    logic [N-1:0] h;
    cycle++;
    if (!reset_n) begin
      exp_q.push_back('0);
    end else begin
      tk = (m_c == TICK - 1);
      if (enable) m_c = (m_c + 1) % TICK;
      else m_c = 0;
      p = '0;
      for (int i = 0; i < N; i++) begin
        if (!enable) begin
          m_active[i] = 1'b0;
        end else if (!m_active[i]) begin
          if (btn_level[i]) begin
            p[i] = 1'b1;
            m_active[i] = 1'b1;
            m_ticks[i] = 0;
            m_target[i] = HOLD;
            m_reps[i] = -1;
          end
        end else if (!btn_level[i]) begin
          m_active[i] = 1'b0;
        end else if (tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == m_target[i]) begin
            p[i] = 1'b1;
            m_reps[i]++;
            m_target[i] += period_for(m_reps[i]);
          end
        end
        h[i] = m_active[i];
      end
      exp_q.push_back({(m_c == TICK - 1) ? 1'b1 : 1'b0, h, p});
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cycle, act, req);
    end
  endtask

  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL queue_empty cycle=%0d actual=0 required=1", cycle);
    end else begin
      e = exp_q.pop_front();
      check("pulse", pulse, e[N-1:0]);
      check("held", held, e[2*N-1:N]);
      check("tick", {{(N-1){1'b0}}, tick}, {{(N-1){1'b0}}, e[2*N]});
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check();
    #2 reset_n = 1'b0;
    #1;
    check("rst_pulse", pulse, '0);
    check("rst_held", held, '0);
    check("rst_tick", {{(N-1){1'b0}}, tick}, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    cyc(3);
    reset_n = 1'b1;
    enable = 1'b1;
    cyc(20);

    btn_level[0] = 1'b1;
    cyc(40);

    btn_level[1] = 1'b1;
    cyc(6);
    btn_level[1] = 1'b0;
    cyc(4);

    btn_level[2] = 1'b1;
    btn_level[4] = 1'b1;
    cyc(20);
    for (int k = 0; k < 200; k++) begin
      if (m_c == TICK - 1 && m_active[2] && m_ticks[2] + 1 == m_target[2]) break;
      cyc(1);
    end
    btn_level[2] = 1'b0;
    cyc(20);

    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(20);

    btn_level[0] = 1'b0;
    cyc(1);
    btn_level[0] = 1'b1;
    cyc(30);

    btn_level = '0;
    cyc(3);
    btn_level[3] = 1'b1;
    cyc(3);
    async_reset_check();
    cyc(10);

    repeat (800) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) btn_level[i] = ~btn_level[i];
      end
      if ($urandom_range(0, 99) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      cyc(1);
    end

    enable = 1'b1;
    btn_level = '0;
    cyc(5);
    #3;
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
